// File: rtl/sdram_port_arbiter.sv
// Two-requester round-robin arbiter in front of an SDRAM controller. A tag FIFO
// records which requester issued each accepted read so returns can be steered back.
module sdram_port_arbiter #(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 16,
  parameter int MAX_PEND = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [ADDR_W-1:0] r0_address,
  input  logic              r0_read,
  input  logic              r0_write,
  input  logic [DATA_W-1:0] r0_writedata,
  output logic              r0_waitrequest,
  output logic [DATA_W-1:0] r0_readdata,
  output logic              r0_readdatavalid,
  input  logic [ADDR_W-1:0] r1_address,
  input  logic              r1_read,
  input  logic              r1_write,
  input  logic [DATA_W-1:0] r1_writedata,
  output logic              r1_waitrequest,
  output logic [DATA_W-1:0] r1_readdata,
  output logic              r1_readdatavalid,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  input  logic              m_waitrequest,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_readdatavalid,
  output logic              err_unexpected
);
  localparam int PW = $clog2(MAX_PEND);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t              state_q;
  logic                grant_q;
  logic                last_grant_q;
  logic                err_q;
  logic [MAX_PEND-1:0] tag_q, tag_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;

  logic not_full_s, elig0_s, elig1_s;
  logic accept_s, push_s, pop_s, head_s;

  assign not_full_s = (count_q < CW'(MAX_PEND));
  assign elig0_s    = r0_write | (r0_read & not_full_s);
  assign elig1_s    = r1_write | (r1_read & not_full_s);

  // Command path: the granted requester is forwarded only while BUSY.
  always_comb begin
    m_address   = {ADDR_W{1'b0}};
    m_read      = 1'b0;
    m_write     = 1'b0;
    m_writedata = {DATA_W{1'b0}};
    if (state_q == BUSY) begin
      if (grant_q) begin
        m_address   = r1_address;
        m_read      = r1_read;
        m_write     = r1_write;
        m_writedata = r1_writedata;
      end else begin
        m_address   = r0_address;
        m_read      = r0_read;
        m_write     = r0_write;
        m_writedata = r0_writedata;
      end
    end else begin
      m_address   = {ADDR_W{1'b0}};
      m_read      = 1'b0;
      m_write     = 1'b0;
      m_writedata = {DATA_W{1'b0}};
    end
  end

  assign accept_s       = (state_q == BUSY) & (m_read | m_write) & ~m_waitrequest;
  assign r0_waitrequest = ~(accept_s & ~grant_q);
  assign r1_waitrequest = ~(accept_s & grant_q);

  // A read accepted while full can only come from a protocol violation; it is not tracked.
  assign pop_s  = m_readdatavalid & (count_q != {CW{1'b0}});
  assign push_s = accept_s & m_read & (not_full_s | pop_s);
  assign head_s = tag_q[rd_ptr_q];

  assign r0_readdatavalid = pop_s & ~head_s;
  assign r1_readdatavalid = pop_s & head_s;
  assign r0_readdata      = m_readdata;
  assign r1_readdata      = m_readdata;
  assign err_unexpected   = err_q;

  // Tag FIFO next state; pointers wrap naturally since MAX_PEND is a power of two.
  always_comb begin
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      tag_d[wr_ptr_q] = grant_q;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Tag FIFO and sticky error registers.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      tag_q    <= {MAX_PEND{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      err_q    <= 1'b0;
    end else begin
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_q | (m_readdatavalid & (count_q == {CW{1'b0}}));
    end
  end

  // Arbitration FSM; last_grant resets to 1 so r0 wins the first tie.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (elig0_s | elig1_s) begin
            state_q <= BUSY;
            grant_q <= (elig0_s & elig1_s) ? ~last_grant_q : elig1_s;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          if (accept_s) begin
            state_q      <= IDLE;
            last_grant_q <= grant_q;
          end else if (!m_read && !m_write) begin
            state_q <= IDLE;
          end else begin
            state_q <= BUSY;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level model (owner + queue of pending read owners).
module tb_sdram_port_arbiter;
  localparam int ADDR_W   = 24;
  localparam int DATA_W   = 16;
  localparam int MAX_PEND = 4;

  logic              clk_clk;
  logic              reset_reset;
  logic [ADDR_W-1:0] r0_address, r1_address, m_address;
  logic              r0_read, r0_write, r1_read, r1_write;
  logic [DATA_W-1:0] r0_writedata, r1_writedata, m_writedata;
  logic              r0_waitrequest, r1_waitrequest;
  logic [DATA_W-1:0] r0_readdata, r1_readdata, m_readdata;
  logic              r0_readdatavalid, r1_readdatavalid;
  logic              m_read, m_write, m_waitrequest, m_readdatavalid;
  logic              err_unexpected;

  int n_checks;
  int n_fail;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(MAX_PEND)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .r0_address(r0_address), .r0_read(r0_read), .r0_write(r0_write),
    .r0_writedata(r0_writedata), .r0_waitrequest(r0_waitrequest),
    .r0_readdata(r0_readdata), .r0_readdatavalid(r0_readdatavalid),
    .r1_address(r1_address), .r1_read(r1_read), .r1_write(r1_write),
    .r1_writedata(r1_writedata), .r1_waitrequest(r1_waitrequest),
    .r1_readdata(r1_readdata), .r1_readdatavalid(r1_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .err_unexpected(err_unexpected)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic clear_inputs();
    r0_address = '0; r0_read = 1'b0; r0_write = 1'b0; r0_writedata = '0;
    r1_address = '0; r1_read = 1'b0; r1_write = 1'b0; r1_writedata = '0;
    m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  // Leaves the bench at the start of cycle 0 after reset release.
  task automatic apply_reset();
    clear_inputs();
    reset_reset = 1'b1;
    @(posedge clk_clk);
    @(posedge clk_clk);
    #1;
    reset_reset = 1'b0;
  endtask

  task automatic test_reset();
    reset_reset = 1'b1;
    r0_read = 1'b1; r1_write = 1'b1; r0_address = 24'h0ABCDE; r1_writedata = 16'h7777;
    m_waitrequest = 1'b0; m_readdatavalid = 1'b1; m_readdata = 16'hBEEF;
    #2;
    n_checks++;
    if ({m_read, m_write, r0_waitrequest, r1_waitrequest, r0_readdatavalid, r1_readdatavalid, err_unexpected} !== 7'b0011000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0011000", {m_read, m_write, r0_waitrequest, r1_waitrequest, r0_readdatavalid, r1_readdatavalid, err_unexpected});
    end
    n_checks++;
    if ({m_address, m_writedata} !== 40'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", {m_address, m_writedata});
    end
    n_checks++;
    if ({r0_readdata, r1_readdata} !== 32'hBEEFBEEF) begin
      n_fail++;
      $display("FAIL readdata_fanout: got %h want beefbeef", {r0_readdata, r1_readdata});
    end
    tick();
    n_checks++;
    if ({m_read, m_write, r0_waitrequest, r1_waitrequest, r0_readdatavalid, r1_readdatavalid, err_unexpected} !== 7'b0011000) begin
      n_fail++;
      $display("FAIL reset_held_edge: got %b want 0011000", {m_read, m_write, r0_waitrequest, r1_waitrequest, r0_readdatavalid, r1_readdatavalid, err_unexpected});
    end
    clear_inputs();
    reset_reset = 1'b0;
    @(negedge clk_clk);
    n_checks++;
    if ({m_read, m_write, r0_waitrequest, r1_waitrequest} !== 4'b0011) begin
      n_fail++;
      $display("FAIL reset_idle: got %b want 0011", {m_read, m_write, r0_waitrequest, r1_waitrequest});
    end
  endtask

  task automatic test_alternating_reads();
    logic [ADDR_W-1:0] a0, a1, exp_addr;
    logic [1:0]        exp_w;
    logic              exp_mr;
    a0 = 24'h00A010; a1 = 24'h00B020;
    apply_reset();
    r0_address = a0; r1_address = a1; r0_read = 1'b1; r1_read = 1'b1;
    @(negedge clk_clk);
    n_checks++;
    if ({m_read, r0_waitrequest, r1_waitrequest} !== 3'b011) begin
      n_fail++;
      $display("FAIL alt_c0: got %b want 011", {m_read, r0_waitrequest, r1_waitrequest});
    end
    for (int c = 1; c <= 9; c++) begin
      tick();
      @(negedge clk_clk);
      if ((c % 2 == 1) && (c <= 7)) begin
        exp_mr   = 1'b1;
        exp_addr = (c % 4 == 1) ? a0 : a1;
        exp_w    = (c % 4 == 1) ? 2'b01 : 2'b10;
      end else begin
        exp_mr   = 1'b0;
        exp_addr = '0;
        exp_w    = 2'b11;
      end
      n_checks++;
      if ({m_read, m_address, r0_waitrequest, r1_waitrequest} !== {exp_mr, exp_addr, exp_w}) begin
        n_fail++;
        $display("FAIL alt_c%0d: got %h want %h", c, {m_read, m_address, r0_waitrequest, r1_waitrequest}, {exp_mr, exp_addr, exp_w});
      end
    end
  endtask

  task automatic test_write_stall();
    apply_reset();
    m_waitrequest = 1'b1; r1_address = 24'h123456; r1_writedata = 16'hCAFE; r1_write = 1'b1;
    @(negedge clk_clk);
    n_checks++;
    if ({m_write, r1_waitrequest} !== 2'b01) begin
      n_fail++;
      $display("FAIL stall_c0: got %b want 01", {m_write, r1_waitrequest});
    end
    for (int c = 1; c <= 5; c++) begin
      tick();
      @(negedge clk_clk);
      n_checks++;
      if ({m_write, m_address, m_writedata, r0_waitrequest, r1_waitrequest} !== {1'b1, 24'h123456, 16'hCAFE, 2'b11}) begin
        n_fail++;
        $display("FAIL stall_c%0d: got %h want %h", c, {m_write, m_address, m_writedata, r0_waitrequest, r1_waitrequest}, {1'b1, 24'h123456, 16'hCAFE, 2'b11});
      end
    end
    tick();
    m_waitrequest = 1'b0;
    @(negedge clk_clk);
    n_checks++;
    if ({m_write, r0_waitrequest, r1_waitrequest} !== 3'b110) begin
      n_fail++;
      $display("FAIL stall_accept: got %b want 110", {m_write, r0_waitrequest, r1_waitrequest});
    end
    tick();
    r1_write = 1'b0;
    @(negedge clk_clk);
    n_checks++;
    if ({m_write, r1_waitrequest} !== 2'b01) begin
      n_fail++;
      $display("FAIL stall_idle: got %b want 01", {m_write, r1_waitrequest});
    end
  endtask

  task automatic test_fifo_full();
    apply_reset();
    r0_read = 1'b1; r0_address = 24'h000100; r1_address = 24'h000200;
    for (int c = 1; c <= 7; c++) tick();
    @(negedge clk_clk);
    n_checks++;
    if ({m_read, r0_waitrequest} !== 2'b10) begin
      n_fail++;
      $display("FAIL full_4th_read: got %b want 10", {m_read, r0_waitrequest});
    end
    tick();
    r1_write = 1'b1; r1_writedata = 16'h5A5A;
    @(negedge clk_clk);
    n_checks++;
    if ({m_read, m_write} !== 2'b00) begin
      n_fail++;
      $display("FAIL full_c8: got %b want 00", {m_read, m_write});
    end
    tick();
    @(negedge clk_clk);
    n_checks++;
    if ({m_read, m_write, m_address, r0_waitrequest, r1_waitrequest} !== {2'b01, 24'h000200, 2'b10}) begin
      n_fail++;
      $display("FAIL full_write_granted: got %h want %h", {m_read, m_write, m_address, r0_waitrequest, r1_waitrequest}, {2'b01, 24'h000200, 2'b10});
    end
    tick();
    r1_write = 1'b0;
    tick();
    @(negedge clk_clk);
    n_checks++;
    if ({m_read, r0_waitrequest} !== 2'b01) begin
      n_fail++;
      $display("FAIL full_read_blocked: got %b want 01", {m_read, r0_waitrequest});
    end
    tick();
    m_readdatavalid = 1'b1; m_readdata = 16'h0F0F;
    @(negedge clk_clk);
    n_checks++;
    if ({r0_readdatavalid, r1_readdatavalid, r0_readdata} !== {2'b10, 16'h0F0F}) begin
      n_fail++;
      $display("FAIL full_return: got %h want %h", {r0_readdatavalid, r1_readdatavalid, r0_readdata}, {2'b10, 16'h0F0F});
    end
    tick();
    m_readdatavalid = 1'b0;
    tick();
    @(negedge clk_clk);
    n_checks++;
    if ({m_read, m_address, r0_waitrequest} !== {1'b1, 24'h000100, 1'b0}) begin
      n_fail++;
      $display("FAIL full_5th_read: got %h want %h", {m_read, m_address, r0_waitrequest}, {1'b1, 24'h000100, 1'b0});
    end
  endtask

  task automatic test_return_order();
    logic [DATA_W-1:0] vals [3];
    logic [1:0]        vmask [3];
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
    vmask[0] = 2'b10; vmask[1] = 2'b01; vmask[2] = 2'b10;
    apply_reset();
    r0_read = 1'b1; r1_read = 1'b1;
    for (int c = 1; c <= 5; c++) tick();
    @(negedge clk_clk);
    n_checks++;
    if ({m_read, r0_waitrequest, r1_waitrequest} !== 3'b101) begin
      n_fail++;
      $display("FAIL order_third_read: got %b want 101", {m_read, r0_waitrequest, r1_waitrequest});
    end
    tick();
    r0_read = 1'b0; r1_read = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      m_readdatavalid = 1'b1; m_readdata = vals[k];
      @(negedge clk_clk);
      n_checks++;
      if ({r0_readdatavalid, r1_readdatavalid, r0_readdata, r1_readdata} !== {vmask[k], vals[k], vals[k]}) begin
        n_fail++;
        $display("FAIL order_ret%0d: got %h want %h", k, {r0_readdatavalid, r1_readdatavalid, r0_readdata, r1_readdata}, {vmask[k], vals[k], vals[k]});
      end
    end
    tick();
    m_readdatavalid = 1'b0;
    @(negedge clk_clk);
    n_checks++;
    if ({r0_readdatavalid, r1_readdatavalid, err_unexpected} !== 3'b000) begin
      n_fail++;
      $display("FAIL order_after: got %b want 000", {r0_readdatavalid, r1_readdatavalid, err_unexpected});
    end
  endtask

  task automatic test_unexpected();
    apply_reset();
    tick();
    m_readdatavalid = 1'b1; m_readdata = 16'hDEAD;
    @(negedge clk_clk);
    n_checks++;
    if ({r0_readdatavalid, r1_readdatavalid, err_unexpected} !== 3'b000) begin
      n_fail++;
      $display("FAIL unexp_same_cycle: got %b want 000", {r0_readdatavalid, r1_readdatavalid, err_unexpected});
    end
    tick();
    m_readdatavalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_clk);
      n_checks++;
      if (err_unexpected !== 1'b1) begin
        n_fail++;
        $display("FAIL unexp_sticky%0d: got %b want 1", k, err_unexpected);
      end
      tick();
    end
    reset_reset = 1'b1;
    #1;
    n_checks++;
    if (err_unexpected !== 1'b0) begin
      n_fail++;
      $display("FAIL unexp_cleared: got %b want 0", err_unexpected);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    r0_address = 24'h00C0DE; r1_address = 24'h00F00D; r0_read = 1'b1; r1_read = 1'b1;
    for (int c = 1; c <= 5; c++) tick();
    m_waitrequest = 1'b1;
    @(negedge clk_clk);
    n_checks++;
    if ({m_read, r0_waitrequest} !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_busy: got %b want 11", {m_read, r0_waitrequest});
    end
    #1;
    reset_reset = 1'b1; m_readdatavalid = 1'b1;
    #1;
    n_checks++;
    if ({m_read, m_write, m_address, m_writedata, r0_waitrequest, r1_waitrequest, r0_readdatavalid, r1_readdatavalid} !== {2'b00, 24'h0, 16'h0, 4'b1100}) begin
      n_fail++;
      $display("FAIL mid_async: got %h want %h", {m_read, m_write, m_address, m_writedata, r0_waitrequest, r1_waitrequest, r0_readdatavalid, r1_readdatavalid}, {2'b00, 24'h0, 16'h0, 4'b1100});
    end
    tick();
    reset_reset = 1'b0; m_waitrequest = 1'b0;
    @(negedge clk_clk);
    n_checks++;
    if ({r0_readdatavalid, r1_readdatavalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_stale_return: got %b want 00", {r0_readdatavalid, r1_readdatavalid});
    end
    tick();
    m_readdatavalid = 1'b0;
    @(negedge clk_clk);
    n_checks++;
    if ({m_read, m_address, r0_waitrequest, r1_waitrequest, err_unexpected} !== {1'b1, 24'h00C0DE, 3'b011}) begin
      n_fail++;
      $display("FAIL mid_first_grant: got %h want %h", {m_read, m_address, r0_waitrequest, r1_waitrequest, err_unexpected}, {1'b1, 24'h00C0DE, 3'b011});
    end
  endtask

  task automatic test_random();
    int                owner, last, acc_owner, op;
    int                pend[$];
    bit                err_m, acc, do_push, do_pop, e0, e1;
    logic              exp_mr, exp_mw, exp_w0, exp_w1, exp_v0, exp_v1;
    logic [ADDR_W-1:0] exp_ma;
    logic [DATA_W-1:0] exp_md;
    logic [78:0]       got, want;
    apply_reset();
    owner = -1; last = 1; err_m = 1'b0; pend.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      // A granted requester usually holds its command; occasionally it abandons it.
      if (owner == 0) begin
        if ($urandom_range(0, 7) == 0) begin r0_read = 1'b0; r0_write = 1'b0; end
      end else begin
        op = $urandom_range(0, 3);
        r0_read = (op == 1); r0_write = (op == 2);
        r0_address = 24'($urandom); r0_writedata = 16'($urandom);
      end
      if (owner == 1) begin
        if ($urandom_range(0, 7) == 0) begin r1_read = 1'b0; r1_write = 1'b0; end
      end else begin
        op = $urandom_range(0, 3);
        r1_read = (op == 1); r1_write = (op == 2);
        r1_address = 24'($urandom); r1_writedata = 16'($urandom);
      end
      m_waitrequest   = ($urandom_range(0, 2) == 0);
      m_readdatavalid = ($urandom_range(0, 3) == 0);
      m_readdata      = 16'($urandom);

      exp_mr = 1'b0; exp_mw = 1'b0; exp_ma = '0; exp_md = '0;
      if (owner == 0) begin
        exp_mr = r0_read; exp_mw = r0_write; exp_ma = r0_address; exp_md = r0_writedata;
      end else if (owner == 1) begin
        exp_mr = r1_read; exp_mw = r1_write; exp_ma = r1_address; exp_md = r1_writedata;
      end
      acc    = (owner >= 0) && (exp_mr || exp_mw) && !m_waitrequest;
      exp_w0 = !(acc && owner == 0);
      exp_w1 = !(acc && owner == 1);
      exp_v0 = 1'b0; exp_v1 = 1'b0;
      if (m_readdatavalid && pend.size() > 0) begin
        if (pend[0] == 0) exp_v0 = 1'b1;
        else exp_v1 = 1'b1;
      end

      @(negedge clk_clk);
      got  = {m_read, m_write, m_address, m_writedata, r0_waitrequest, r1_waitrequest,
              r0_readdatavalid, r1_readdatavalid, err_unexpected, r0_readdata, r1_readdata};
      want = {exp_mr, exp_mw, exp_ma, exp_md, exp_w0, exp_w1, exp_v0, exp_v1, err_m, m_readdata, m_readdata};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL random_cyc%0d: got %h want %h", cyc, got, want);
      end

      do_pop = m_readdatavalid && (pend.size() > 0);
      if (m_readdatavalid && pend.size() == 0) err_m = 1'b1;
      do_push = 1'b0; acc_owner = owner;
      if (owner >= 0) begin
        if (acc) begin
          last = owner;
          do_push = exp_mr && ((pend.size() < MAX_PEND) || do_pop);
          owner = -1;
        end else if (!exp_mr && !exp_mw) begin
          owner = -1;
        end
      end else begin
        e0 = r0_write || (r0_read && pend.size() < MAX_PEND);
        e1 = r1_write || (r1_read && pend.size() < MAX_PEND);
        if (e0 && e1) owner = 1 - last;
        else if (e0) owner = 0;
        else if (e1) owner = 1;
      end
      if (do_pop) void'(pend.pop_front());
      if (do_push) pend.push_back(acc_owner);
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_reset = 1'b1;
    clear_inputs();
    test_reset();
    test_alternating_reads();
    test_write_stall();
    test_fifo_full();
    test_return_order();
    test_unexpected();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, the word address width on all ports.
REQ-002 SHALL have parameter DATA_W, default 16, the data width on all ports.
REQ-003 SHALL have parameter MAX_PEND, default 4, the maximum number of outstanding reads (a power of 2, at least 2).
REQ-004 clk_clk  in  1  the single clock; all logic is on its rising edge.
REQ-005 reset_reset  in  1  the reset, asynchronous and active-high.
REQ-006 rN_address / rN_read / rN_write / rN_writedata  in  ADDR_W/1/1/DATA_W  the requester N command (N = 0, 1).
REQ-007 rN_waitrequest  out  1  the requester N stall signal.
REQ-008 rN_readdata / rN_readdatavalid  out  DATA_W/1  the requester N read return.
REQ-009 m_address / m_read / m_write / m_writedata  out  ADDR_W/1/1/DATA_W  the command to the SDRAM controller.
REQ-010 m_waitrequest / m_readdata / m_readdatavalid  in  1/DATA_W/1  the SDRAM controller response.
REQ-011 err_unexpected  out  1  sticky flag for a read return with no read outstanding.

Function
REQ-012 SHALL implement an FSM with two states: IDLE and BUSY.
REQ-013 A requester SHALL be eligible when it asserts a write, or asserts a read while the pending count is below MAX_PEND.
REQ-014 In IDLE, if any requester is eligible, the FSM SHALL register grant (a 1-bit requester index) and enter BUSY on the next edge.
REQ-015 Grant selection SHALL be round-robin: if both requesters are eligible, the one not granted last wins; if only one is eligible, it wins.
REQ-016 In BUSY, m_address, m_read, m_write and m_writedata SHALL combinationally follow the granted requester's inputs.
REQ-017 In IDLE, m_read and m_write SHALL be 0, and m_address and m_writedata SHALL be 0.
REQ-018 A command SHALL be accepted in a BUSY cycle where (m_read or m_write) and m_waitrequest is 0.
REQ-019 rN_waitrequest SHALL be 0 only in the acceptance cycle of requester N; it SHALL be 1 in all other cycles.
REQ-020 On acceptance the FSM SHALL return to IDLE, so each command costs at least 2 cycles.
REQ-021 On acceptance the arbiter SHALL record last_grant = grant.
REQ-022 If the granted requester deasserts both read and write in BUSY, the FSM SHALL return to IDLE with no acceptance and no change to last_grant.
REQ-023 If a requester asserts read and write together, the command SHALL be forwarded as-is; this is the requester's fault and needs no special handling.
REQ-024 A tag FIFO of depth MAX_PEND SHALL push the grant index on each accepted read and pop on each m_readdatavalid.
REQ-025 On m_readdatavalid with the FIFO non-empty, the arbiter SHALL set rN_readdatavalid = 1 for the requester N at the FIFO head, in the same cycle.
REQ-026 m_readdata SHALL drive both rN_readdata outputs unconditionally.
REQ-027 The pending count SHALL equal the FIFO occupancy; a simultaneous push and pop SHALL leave it unchanged, and the pointers SHALL wrap modulo MAX_PEND.
REQ-028 While the count equals MAX_PEND, reads SHALL be ineligible and writes SHALL still be granted.
REQ-029 An m_readdatavalid with an empty FIFO SHALL produce no rN_readdatavalid, SHALL leave the pointers unchanged, and SHALL set err_unexpected, which stays 1 until reset.

Reset
REQ-030 Asserting reset_reset at any time, including mid-operation, SHALL immediately force: state IDLE, FIFO empty (count 0), last_grant = 1 (so r0 wins the first tie), err_unexpected = 0.
REQ-031 During reset, all m_* command outputs and rN_readdatavalid SHALL be 0, and both rN_waitrequest SHALL be 1.
REQ-032 Reads in flight at reset SHALL be discarded; their later returns SHALL set err_unexpected.

Verification
REQ-033 r0 and r1 both read from cycle 0 after reset, m_waitrequest = 0 -> r0 is accepted in cycle 1 and r1 in cycle 3; m_address alternates between the two.
REQ-034 r1 writes with m_waitrequest held high for 5 cycles -> m_write = 1 and r1_waitrequest = 1 for 5 cycles, then one acceptance cycle with r1_waitrequest = 0, then IDLE.
REQ-035 r0 issues 4 reads with no returns (MAX_PEND = 4) -> a 5th r0 read is not granted while a concurrent r1 write is granted; one return then allows the 5th read.
REQ-036 Reads are issued r0, r1, r0 and three returns arrive with values 0x1111, 0x2222, 0x3333 -> r0, r1, r0 each get a 1-cycle readdatavalid with the matching data.
REQ-037 m_readdatavalid arrives with nothing pending -> no rN_readdatavalid, err_unexpected = 1 until reset.
REQ-038 reset_reset is pulsed while in BUSY with 2 reads pending -> outputs return to reset values with no clock edge; the first request after reset goes to r0.
